// File: rtl/raisin64_io_pkg.sv
// rtl/raisin64_io_pkg.sv - shared page constants, device and state encodings for the IO responder
package raisin64_io_pkg;

    localparam logic [33:0] LED_PAGE = 34'h2_0000_0001;
    localparam logic [33:0] SW_PAGE  = 34'h2_0000_0002;
    localparam logic [33:0] VGA_PAGE = 34'h2_0000_0003;

    typedef enum logic [1:0] {
        DEV_NONE,
        DEV_LED,
        DEV_SW,
        DEV_VGA
    } dev_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

endpackage

// File: rtl/io_page_decode.sv
// rtl/io_page_decode.sv - maps addr[47:14] to the peripheral it selects
module io_page_decode
    import raisin64_io_pkg::*;
#(
    parameter logic [33:0] LED_PG = LED_PAGE,
    parameter logic [33:0] SW_PG  = SW_PAGE,
    parameter logic [33:0] VGA_PG = VGA_PAGE
) (
    input  logic [33:0] i_page,
    output dev_t        o_dev
);

    // Bit 33 is addr[47]; the lower half of the address space is never IO.
    always_comb begin
        o_dev = DEV_NONE;
        if (i_page[33]) begin
            if (i_page == LED_PG)
                o_dev = DEV_LED;
            else if (i_page == SW_PG)
                o_dev = DEV_SW;
            else if (i_page == VGA_PG)
                o_dev = DEV_VGA;
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - single-outstanding CPU responder for the upper-half IO space
module io_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [33:0] LED_PAGE       = 34'h2_0000_0001,
    parameter logic [33:0] SW_PAGE        = 34'h2_0000_0002,
    parameter logic [33:0] VGA_PAGE       = 34'h2_0000_0003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [63:0] cpu_rdata,
    output logic        cpu_err,
    output logic [13:0] io_addr,
    output logic [63:0] io_wdata,
    output logic        io_we,
    output logic        led_stb,
    output logic        sw_stb,
    output logic        vga_stb,
    input  logic        led_ack,
    input  logic        sw_ack,
    input  logic        vga_ack,
    input  logic [63:0] led_rdata,
    input  logic [63:0] sw_rdata,
    input  logic [63:0] vga_rdata
);
    import raisin64_io_pkg::*;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    dev_t        r_dev;
    dev_t        w_dec_dev;
    logic [13:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_we;
    logic [15:0] r_cnt;
    logic [63:0] r_rdata;
    logic        r_err;
    logic        w_ack;
    logic [63:0] w_ack_rdata;
    logic        w_timeout;
    logic        w_unused_addr;

    assign w_unused_addr = &{1'b0, cpu_addr[63:48]};

    io_page_decode #(
        .LED_PG (LED_PAGE),
        .SW_PG  (SW_PAGE),
        .VGA_PG (VGA_PAGE)
    ) u_decode (
        .i_page (cpu_addr[47:14]),
        .o_dev  (w_dec_dev)
    );

    // Only the selected device's ack and data are looked at; others are don't-care.
    always_comb begin
        w_ack       = 1'b0;
        w_ack_rdata = 64'd0;
        case (r_dev)
            DEV_LED: begin w_ack = led_ack; w_ack_rdata = led_rdata; end
            DEV_SW:  begin w_ack = sw_ack;  w_ack_rdata = sw_rdata;  end
            DEV_VGA: begin w_ack = vga_ack; w_ack_rdata = vga_rdata; end
            default: ;
        endcase
    end

    assign w_timeout = (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req)
                          w_next_state = (w_dec_dev == DEV_NONE) ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_ack || w_timeout)
                          w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dev   <= DEV_NONE;
            r_addr  <= 14'd0;
            r_wdata <= 64'd0;
            r_we    <= 1'b0;
            r_cnt   <= 16'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr[13:0];
                        r_wdata <= cpu_wdata;
                        r_we    <= cpu_we;
                        r_dev   <= w_dec_dev;
                        r_cnt   <= 16'd0;
                        if (w_dec_dev == DEV_NONE) begin
                            r_rdata <= 64'd0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is tested first so it wins over a simultaneous timeout.
                    if (w_ack) begin
                        r_rdata <= r_we ? 64'd0 : w_ack_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 64'd0;
                        r_err   <= 1'b1;
                    end
                    if (r_cnt != 16'hFFFF)
                        r_cnt <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready = (r_state == S_RESP);
    assign cpu_rdata = r_rdata;
    assign cpu_err   = r_err;
    assign io_addr   = r_addr;
    assign io_wdata  = r_wdata;
    assign io_we     = r_we;
    assign led_stb   = (r_state == S_ACCESS) && (r_dev == DEV_LED);
    assign sw_stb    = (r_state == S_ACCESS) && (r_dev == DEV_SW);
    assign vga_stb   = (r_state == S_ACCESS) && (r_dev == DEV_VGA);

endmodule

// File: tb/tb_io_bus_responder.sv
// tb/tb_io_bus_responder.sv - directed scoreboard bench for io_bus_responder
module tb_io_bus_responder;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_ready;
    logic [63:0] cpu_rdata;
    logic        cpu_err;
    logic [13:0] io_addr;
    logic [63:0] io_wdata;
    logic        io_we;
    logic        led_stb;
    logic        sw_stb;
    logic        vga_stb;
    logic        led_ack;
    logic        sw_ack;
    logic        vga_ack;
    logic [63:0] led_rdata;
    logic [63:0] sw_rdata;
    logic [63:0] vga_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          ready_cyc;
        int          stb_cyc;
        int          dev;
    } exp_t;

    exp_t sb[$];

    io_bus_responder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_we     (io_we),
        .led_stb   (led_stb),
        .sw_stb    (sw_stb),
        .vga_stb   (vga_stb),
        .led_ack   (led_ack),
        .sw_ack    (sw_ack),
        .vga_ack   (vga_ack),
        .led_rdata (led_rdata),
        .sw_rdata  (sw_rdata),
        .vga_rdata (vga_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_dev(input logic [63:0] addr);
        logic [33:0] page;
        page = addr[47:14];
        if (page == 34'h2_0000_0001) return 1;
        if (page == 34'h2_0000_0002) return 2;
        if (page == 34'h2_0000_0003) return 3;
        return 0;
    endfunction

    function automatic logic stb_of(input int dev);
        case (dev)
            1:       return led_stb;
            2:       return sw_stb;
            3:       return vga_stb;
            default: return 1'b0;
        endcase
    endfunction

    // ack_cyc = 0 means the selected device never acks.
    task automatic run_txn(input string tag, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input int ack_cyc,
                           input logic [63:0] ack_data, input bit strays);
        exp_t e;
        exp_t got;
        bit   done;
        int   sel_cnt;
        int   other_cnt;
        int   rdy_cyc;
        e.dev = model_dev(addr);
        if (e.dev == 0) begin
            e.rdata = 64'd0; e.err = 1'b1; e.ready_cyc = 1; e.stb_cyc = 0;
        end else if (ack_cyc >= 1 && ack_cyc <= TO) begin
            e.rdata = we ? 64'd0 : ack_data; e.err = 1'b0;
            e.ready_cyc = ack_cyc + 1; e.stb_cyc = ack_cyc;
        end else begin
            e.rdata = 64'd0; e.err = 1'b1; e.ready_cyc = TO + 1; e.stb_cyc = TO;
        end
        sb.push_back(e);

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        done = 0; sel_cnt = 0; other_cnt = 0; rdy_cyc = 0;
        for (int c = 1; c <= TO + 4 && !done; c++) begin
            @(negedge clk);
            led_ack = 1'b0; sw_ack = 1'b0; vga_ack = 1'b0;
            if (stb_of(e.dev)) sel_cnt++;
            if ((32'(led_stb) + 32'(sw_stb) + 32'(vga_stb)) > 32'(stb_of(e.dev))) other_cnt++;
            if (c == 1 && e.dev != 0) begin
                check({tag, " io_addr"},  64'(io_addr), 64'(addr[13:0]));
                check({tag, " io_we"},    64'(io_we),   64'(we));
                check({tag, " io_wdata"}, io_wdata,     wdata);
            end
            if (cpu_ready) begin
                rdy_cyc = c;
                got = sb.pop_front();
                check({tag, " ready_cycle"}, 64'(rdy_cyc),   64'(got.ready_cyc));
                check({tag, " rdata"},       cpu_rdata,      got.rdata);
                check({tag, " err"},         64'(cpu_err),   64'(got.err));
                check({tag, " stb_cycles"},  64'(sel_cnt),   64'(got.stb_cyc));
                check({tag, " other_stb"},   64'(other_cnt), 64'd0);
                cpu_req = 1'b0;
                done = 1;
            end else begin
                if (c == ack_cyc) begin
                    case (e.dev)
                        1: begin led_ack = 1'b1; led_rdata = ack_data; end
                        2: begin sw_ack  = 1'b1; sw_rdata  = ack_data; end
                        3: begin vga_ack = 1'b1; vga_rdata = ack_data; end
                        default: ;
                    endcase
                end
                if (strays && (c == 2 || c == 3)) begin
                    led_ack = 1'b1; led_rdata = 64'hDEAD_BEEF_0000_0001;
                    sw_ack  = 1'b1; sw_rdata  = 64'hDEAD_BEEF_0000_0002;
                end
            end
        end
        led_ack = 1'b0; sw_ack = 1'b0; vga_ack = 1'b0;
        if (!done) begin
            check({tag, " ready_seen"}, 64'd0, 64'd1);
            cpu_req = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        led_ack = 1'b0; sw_ack = 1'b0; vga_ack = 1'b0;
        led_rdata = 64'd0; sw_rdata = 64'd0; vga_rdata = 64'd0;
        repeat (3) @(negedge clk);
        check("reset ready",  64'(cpu_ready), 64'd0);
        check("reset rdata",  cpu_rdata,      64'd0);
        check("reset err",    64'(cpu_err),   64'd0);
        check("reset stbs",   64'({led_stb, sw_stb, vga_stb}), 64'd0);
        check("reset io_addr", 64'(io_addr),  64'd0);
        check("reset io_we",  64'(io_we),     64'd0);
        check("reset io_wdata", io_wdata,     64'd0);
        rst_n = 1'b1;

        run_txn("sw_read",      1'b0, 64'hFFFF_8000_0000_8010, 64'd0,  2, 64'h5A, 0);
        run_txn("led_write",    1'b1, 64'hFFFF_8000_0000_4000, 64'hF0, 1, 64'h77, 0);
        run_txn("unmapped_p4",  1'b0, 64'hFFFF_8000_0001_0000, 64'd0,  1, 64'h11, 0);
        run_txn("low_half",     1'b0, 64'h0000_0000_0000_8010, 64'd0,  1, 64'h22, 0);
        run_txn("vga_timeout",  1'b0, 64'hFFFF_8000_0000_C004, 64'd0,  0, 64'h33, 0);
        run_txn("vga_strays",   1'b0, 64'hFFFF_8000_0000_C100, 64'd0,  4, 64'h1234, 1);
        run_txn("ack_at_limit", 1'b0, 64'hFFFF_8000_0000_C3FF, 64'd0, TO, 64'hCAFE, 0);
        run_txn("sw_write",     1'b1, 64'hFFFF_8000_0000_BFFF, 64'hAB, 3, 64'h99, 0);

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'hFFFF_8000_0000_C008; cpu_wdata = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_pre vga_stb", 64'(vga_stb), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async stbs",  64'({led_stb, sw_stb, vga_stb}), 64'd0);
        check("rst_async ready", 64'(cpu_ready), 64'd0);
        cpu_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_ready) pulses++;
        end
        check("rst_no_ready", 64'(pulses), 64'd0);
        rst_n = 1'b1;
        run_txn("post_reset", 1'b0, 64'hFFFF_8000_0000_8020, 64'd0, 1, 64'h4242, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
